sram_sp_arbiter: RTL and testbench

Sequencing controller for a single-port, way-masked SRAM macro of 32 sets × 2 ways × 74 bits. It shares the one RW port between a read requester and a write requester, and zero-initialises the array after reset. Read data is held stable between responses, and reads are protected from starvation. It sits between a cache/predictor table pipeline and the generated `*_ext` SRAM macro.

---
 rtl/sram_arb_pkg.sv | 22 ++
 rtl/sram_arb_grant.sv | 49 ++++
 rtl/sram_sp_arbiter.sv | 140 ++++++++++++++
 tb/tb_sram_sp_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default constants for the single-port SRAM arbiter.
// Widths in sram_wreq_t follow the default geometry below.
package sram_arb_pkg;

  localparam int SETS         = 32;
  localparam int WAYS         = 2;
  localparam int WAY_BITS     = 74;
  localparam int STARVE_LIMIT = 3;

  typedef enum logic [1:0] {
    PRE  = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [$clog2(SETS)-1:0]  set;
    logic [WAYS-1:0]          waymask;
    logic [WAYS*WAY_BITS-1:0] data;
  } sram_wreq_t;

endpackage

// File: rtl/sram_arb_grant.sv
// Read/write grant selection for the shared SRAM port, plus the read starvation counter.
// Optional same-set write-to-read bypass is enabled by defining SRAM_ARB_WBYPASS_EN.
module sram_arb_grant #(
  parameter int AW           = 5,
  parameter int WAYS         = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            i_run,
  input  logic            i_r_valid,
  input  logic [AW-1:0]   i_r_set,
  input  logic            i_w_valid,
  input  logic [AW-1:0]   i_w_set,
  input  logic [WAYS-1:0] i_w_mask,
  output logic            o_r_grant,
  output logic            o_w_grant,
  output logic            o_bypass
);

  logic [3:0] r_starve_cnt;
  logic       w_starved;
  logic       w_read_wins;

  assign w_starved = (r_starve_cnt == 4'(STARVE_LIMIT));

  // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_bypass = 1'b0;
`ifdef SRAM_ARB_WBYPASS_EN
    o_bypass = i_run && i_r_valid && i_w_valid && (i_r_set == i_w_set) && (&i_w_mask);
`endif
    w_read_wins = i_r_valid && (!i_w_valid || w_starved);
    o_r_grant   = i_run && (w_read_wins || o_bypass);
    o_w_grant   = i_run && i_w_valid && (!w_read_wins || o_bypass);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= 4'd0;
    end else if (!i_run || !i_r_valid || o_r_grant) begin
      r_starve_cnt <= 4'd0;
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/sram_sp_arbiter.sv
// Single-port way-masked SRAM sequencer: zero-fill sweep after reset, then read/write arbitration.
// Optional write-to-read bypass is enabled by defining SRAM_ARB_WBYPASS_EN.
module sram_sp_arbiter
  import sram_arb_pkg::*;
#(
  parameter int SETS         = sram_arb_pkg::SETS,
  parameter int WAYS         = sram_arb_pkg::WAYS,
  parameter int WAY_BITS     = sram_arb_pkg::WAY_BITS,
  parameter int STARVE_LIMIT = sram_arb_pkg::STARVE_LIMIT,
  parameter int AW           = $clog2(SETS),
  parameter int DW           = WAYS * WAY_BITS
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            r_req_valid,
  output logic            r_req_ready,
  input  logic [AW-1:0]   r_req_set,
  output logic            r_resp_valid,
  output logic [DW-1:0]   r_resp_data,
  input  logic            w_req_valid,
  output logic            w_req_ready,
  input  logic [AW-1:0]   w_req_set,
  input  logic [WAYS-1:0] w_req_waymask,
  input  logic [DW-1:0]   w_req_data,
  output logic            init_busy,
  output logic            sram_en,
  output logic            sram_wmode,
  output logic [AW-1:0]   sram_addr,
  output logic [WAYS-1:0] sram_wmask,
  output logic [DW-1:0]   sram_wdata,
  input  logic [DW-1:0]   sram_rdata
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_set_cnt;
  logic          w_last_set;
  logic          w_r_grant;
  logic          w_w_grant;
  logic          w_bypass;
  logic          r_rsp_valid;
  logic          r_byp_pend;
  logic [DW-1:0] r_byp_data;
  logic [DW-1:0] r_rsp_data;

  assign w_last_set = (r_set_cnt == AW'(SETS - 1));

  sram_arb_grant #(
    .AW           (AW),
    .WAYS         (WAYS),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_run     (r_state == RUN),
    .i_r_valid (r_req_valid),
    .i_r_set   (r_req_set),
    .i_w_valid (w_req_valid),
    .i_w_set   (w_req_set),
    .i_w_mask  (w_req_waymask),
    .o_r_grant (w_r_grant),
    .o_w_grant (w_w_grant),
    .o_bypass  (w_bypass)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= PRE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PRE:     w_state_nxt = INIT;
      INIT:    if (w_last_set) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = PRE;
    endcase
  end

  always_comb begin
    init_busy   = (r_state != RUN);
    r_req_ready = w_r_grant;
    w_req_ready = w_w_grant;
    sram_en     = 1'b0;
    sram_wmode  = 1'b0;
    sram_addr   = '0;
    sram_wmask  = '0;
    sram_wdata  = '0;
    case (r_state)
      INIT: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = r_set_cnt;
        sram_wmask = '1;
      end
      RUN: begin
        // The write wins the macro port; with bypass the read is served from the write data.
        if (w_w_grant) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = w_req_set;
          sram_wmask = w_req_waymask;
          sram_wdata = w_req_data;
        end else if (w_r_grant) begin
          sram_en    = 1'b1;
          sram_addr  = r_req_set;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_set_cnt <= '0;
    end else if (r_state == INIT) begin
      r_set_cnt <= w_last_set ? '0 : r_set_cnt + 1'b1;
    end
  end

  // Response data loads at the end of the valid cycle, when the macro's read data is present.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_byp_pend  <= 1'b0;
      r_byp_data  <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_r_grant;
      r_byp_pend  <= w_bypass;
      if (w_bypass) r_byp_data <= w_req_data;
      if (r_rsp_valid) r_rsp_data <= r_byp_pend ? r_byp_data : sram_rdata;
    end
  end

  assign r_resp_valid = r_rsp_valid;
  assign r_resp_data  = r_rsp_data;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Self-checking bench for sram_sp_arbiter: SRAM macro model plus a request-level reference model.
// Honours SRAM_ARB_WBYPASS_EN when the design is built with it.
module tb_sram_sp_arbiter;
  import sram_arb_pkg::*;

  localparam int AW = $clog2(SETS);
  localparam int DW = WAYS * WAY_BITS;

  logic            clock;
  logic            reset_n;
  logic            r_req_valid;
  logic            r_req_ready;
  logic [AW-1:0]   r_req_set;
  logic            r_resp_valid;
  logic [DW-1:0]   r_resp_data;
  logic            w_req_valid;
  logic            w_req_ready;
  logic [AW-1:0]   w_req_set;
  logic [WAYS-1:0] w_req_waymask;
  logic [DW-1:0]   w_req_data;
  logic            init_busy;
  logic            sram_en;
  logic            sram_wmode;
  logic [AW-1:0]   sram_addr;
  logic [WAYS-1:0] sram_wmask;
  logic [DW-1:0]   sram_wdata;
  logic [DW-1:0]   sram_rdata;

  sram_sp_arbiter dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .r_req_valid   (r_req_valid),
    .r_req_ready   (r_req_ready),
    .r_req_set     (r_req_set),
    .r_resp_valid  (r_resp_valid),
    .r_resp_data   (r_resp_data),
    .w_req_valid   (w_req_valid),
    .w_req_ready   (w_req_ready),
    .w_req_set     (w_req_set),
    .w_req_waymask (w_req_waymask),
    .w_req_data    (w_req_data),
    .init_busy     (init_busy),
    .sram_en       (sram_en),
    .sram_wmode    (sram_wmode),
    .sram_addr     (sram_addr),
    .sram_wmask    (sram_wmask),
    .sram_wdata    (sram_wdata),
    .sram_rdata    (sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural macro: synchronous read, per-way masked write.
  logic [DW-1:0] sram_mem [SETS];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int i = 0; i < WAYS; i++)
          if (sram_wmask[i]) sram_mem[sram_addr][i*WAY_BITS +: WAY_BITS] <= sram_wdata[i*WAY_BITS +: WAY_BITS];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Reference model state: cycles since reset release, memory contents, pending/held response.
  int            n_vec;
  int            n_err;
  int            cyc;
  int            starve;
  bit            exp_rv;
  logic [DW-1:0] exp_val;
  logic [DW-1:0] exp_hold;
  logic [DW-1:0] ref_mem [SETS];
  bit            last_rready;
  bit            last_wready;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  function automatic sram_wreq_t mk_w(input int set, input int mask, input logic [DW-1:0] data);
    sram_wreq_t w;
    w.set     = AW'(set);
    w.waymask = WAYS'(mask);
    w.data    = data;
    return w;
  endfunction

  // One clock cycle: drive after the falling edge, check, let the rising edge happen, advance model.
  task automatic cycle(input bit rv, input int rs, input bit wv, input sram_wreq_t w);
    bit run, byp, init_wr, rg, wg;
    r_req_valid   = rv;
    r_req_set     = AW'(rs);
    w_req_valid   = wv;
    w_req_set     = w.set;
    w_req_waymask = w.waymask;
    w_req_data    = w.data;
    #1;
    run     = (cyc >= SETS + 1);
    init_wr = (cyc >= 1) && !run;
    byp     = 1'b0;
`ifdef SRAM_ARB_WBYPASS_EN
    byp = run && rv && wv && (AW'(rs) == w.set) && (&w.waymask);
`endif
    rg = run && rv && (!wv || starve == STARVE_LIMIT || byp);
    wg = run && wv && (!(rv && starve == STARVE_LIMIT) || byp);

    chk("init_busy", DW'(init_busy), DW'(!run));
    chk("r_req_ready", DW'(r_req_ready), DW'(rg));
    chk("w_req_ready", DW'(w_req_ready), DW'(wg));
    chk("r_resp_valid", DW'(r_resp_valid), DW'(exp_rv));
    chk("r_resp_data", r_resp_data, exp_hold);
    chk("sram_en", DW'(sram_en), DW'(init_wr || rg || wg));
    if (init_wr) begin
      chk("init_wmode", DW'(sram_wmode), DW'(1));
      chk("init_addr", DW'(sram_addr), DW'(cyc - 1));
      chk("init_wmask", DW'(sram_wmask), DW'({WAYS{1'b1}}));
      chk("init_wdata", sram_wdata, '0);
    end else if (wg) begin
      chk("wr_wmode", DW'(sram_wmode), DW'(1));
      chk("wr_addr", DW'(sram_addr), DW'(w.set));
      chk("wr_wmask", DW'(sram_wmask), DW'(w.waymask));
      chk("wr_wdata", sram_wdata, w.data);
    end else if (rg) begin
      chk("rd_wmode", DW'(sram_wmode), DW'(0));
      chk("rd_addr", DW'(sram_addr), DW'(rs));
    end else begin
      chk("idle_addr", DW'(sram_addr), '0);
      chk("idle_wmask", DW'(sram_wmask), '0);
      chk("idle_wdata", sram_wdata, '0);
    end
    last_rready = r_req_ready;
    last_wready = w_req_ready;

    @(posedge clock);
    if (exp_rv) exp_hold = exp_val;
    exp_rv = rg;
    if (rg) exp_val = byp ? w.data : ref_mem[rs];
    if (init_wr) ref_mem[cyc-1] = '0;
    else if (wg)
      for (int i = 0; i < WAYS; i++)
        if (w.waymask[i]) ref_mem[w.set][i*WAY_BITS +: WAY_BITS] = w.data[i*WAY_BITS +: WAY_BITS];
    starve = (run && rv && !rg) ? ((starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT) : 0;
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, mk_w(0, 0, '0));
  endtask

  // Asserts reset from just after a falling edge, checks reset values, releases two cycles later.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    chk({tag, "_r_req_ready"}, DW'(r_req_ready), '0);
    chk({tag, "_w_req_ready"}, DW'(w_req_ready), '0);
    chk({tag, "_init_busy"}, DW'(init_busy), DW'(1));
    chk({tag, "_sram_en"}, DW'(sram_en), '0);
    chk({tag, "_sram_wmode"}, DW'(sram_wmode), '0);
    chk({tag, "_r_resp_valid"}, DW'(r_resp_valid), '0);
    chk({tag, "_r_resp_data"}, r_resp_data, '0);
    r_req_valid = 1'b0;
    w_req_valid = 1'b0;
    cyc      = 0;
    starve   = 0;
    exp_rv   = 1'b0;
    exp_hold = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [7:0] pat;
    n_vec = 0;
    n_err = 0;
    reset_n       = 1'b0;
    r_req_valid   = 1'b0;
    r_req_set     = '0;
    w_req_valid   = 1'b0;
    w_req_set     = '0;
    w_req_waymask = '0;
    w_req_data    = '0;
    sram_rdata    = rnd_data();
    for (int s = 0; s < SETS; s++) begin
      sram_mem[s] = rnd_data();
      ref_mem[s]  = rnd_data();
    end
    exp_val = '0;
    @(negedge clock);

    // Reset, full zero-fill sweep, then read set 5.
    do_reset("rst0");
    idle(SETS + 1);
    cycle(1'b1, 5, 1'b0, mk_w(0, 0, '0));
    idle(2);
    chk("set5_zero", r_resp_data, '0);

    // Partial-way write then read; held through idles and a later write to the same set.
    cycle(1'b0, 0, 1'b1, mk_w(3, 1, DW'(1)));
    cycle(1'b1, 3, 1'b0, mk_w(0, 0, '0));
    chk("set3_pulse", DW'(r_resp_valid), DW'(1));
    idle(10);
    chk("set3_data", r_resp_data, {74'h0, 74'h1});
    cycle(1'b0, 0, 1'b1, mk_w(3, 3, rnd_data()));
    idle(3);
    chk("set3_hold", r_resp_data, {74'h0, 74'h1});

    // Continuous contention on distinct sets: W,W,W,R repeating.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 10, 1'b1, mk_w(11, 3, rnd_data()));
      pat[i] = last_rready;
    end
    chk("starve_pattern", DW'(pat), DW'(8'b1000_1000));
    idle(2);

    // Read of set 7 followed by a write of set 7: response carries the old value.
    cycle(1'b1, 7, 1'b0, mk_w(0, 0, '0));
    cycle(1'b0, 0, 1'b1, mk_w(7, 3, rnd_data()));
    idle(2);
    chk("rd_before_wr", r_resp_data, '0);
    cycle(1'b1, 7, 1'b0, mk_w(0, 0, '0));
    idle(2);

    // Simultaneous full-mask write and read to set 9.
    cycle(1'b1, 9, 1'b1, mk_w(9, 3, rnd_data()));
`ifdef SRAM_ARB_WBYPASS_EN
    chk("byp_rready", DW'(last_rready), DW'(1));
`else
    chk("byp_rready", DW'(last_rready), DW'(0));
    cycle(1'b1, 9, 1'b0, mk_w(0, 0, '0));
`endif
    idle(2);

    // Randomised traffic over a few sets to force collisions and starvation.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            mk_w($urandom_range(0, 3), $urandom_range(0, 3), rnd_data()));
    idle(2);

    // Reset in the middle of the sweep (set 12 on the macro), with requests asserted.
    do_reset("rst1");
    idle(13);
    chk("mid_init_addr", DW'(sram_addr), DW'(12));
    r_req_valid = 1'b1;
    w_req_valid = 1'b1;
    do_reset("rst2");
    idle(SETS + 3);

    // Reset with a read response in flight: no pulse afterwards, data cleared.
    cycle(1'b0, 0, 1'b1, mk_w(4, 3, rnd_data()));
    cycle(1'b1, 4, 1'b0, mk_w(0, 0, '0));
    chk("inflight_pulse", DW'(r_resp_valid), DW'(1));
    do_reset("rst3");
    idle(SETS + 3);
    cycle(1'b1, 4, 1'b0, mk_w(0, 0, '0));
    idle(2);
    chk("post_reset_zero", r_resp_data, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
